// File: rtl/aer_rx_ctrl_if.sv
// AER bus definitions shared by the pixel-array transmitter and the receiver
// controller: one-hot request code, handshake acknowledge and array reset.
package aer_pkg;
  parameter int AER_OH_WIDTH   = 16;
  localparam int AER_ADDR_WIDTH = $clog2(AER_OH_WIDTH);
endpackage

interface aer_intf;
  import aer_pkg::*;

  logic [AER_OH_WIDTH-1:0] one_hot_code;
  logic                    ack;
  logic                    aer_rst_n;

  // Pixel-array side: raises the one-hot request, follows ack, obeys array reset
  modport transmitter (
    output one_hot_code,
    input  ack,
    input  aer_rst_n
  );

  // Controller side: samples the request and drives ack and array reset
  modport receiver (
    input  one_hot_code,
    output ack,
    output aer_rst_n
  );
endinterface

// File: rtl/aer_rx_ctrl.sv
// AER receiver controller. Synchronizes the asynchronous one-hot request bus,
// debounces it (two matching samples), binary-encodes single-bit requests into
// a valid/ready FIFO, counts multi-bit collisions, and runs the 4-phase
// request/acknowledge handshake. Holds the pixel array in reset for
// ARRAY_RST_CYCLES cycles after system reset.
// Optional feature: define AER_RX_TIMESTAMP_EN to add a 16-bit free-running
// timestamp stored alongside each FIFO entry and presented on evt_ts.
module aer_rx_ctrl
  import aer_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int ARRAY_RST_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  aer_intf.receiver                 aer,
  output logic [AER_ADDR_WIDTH-1:0] evt_addr,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [7:0]                err_cnt,
  input  logic                      err_clr,
  output logic                      fifo_full
`ifdef AER_RX_TIMESTAMP_EN
  ,
  output logic [15:0]               evt_ts
`endif
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int RST_CNT_W = $clog2(ARRAY_RST_CYCLES + 1);
  localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(ARRAY_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CHECK = 2'd2,
    ACK   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  logic [AER_OH_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [AER_OH_WIDTH-1:0] sync_code;

  // First stage captures the asynchronous bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg[0] <= '0;
    else     sync_reg[0] <= aer.one_hot_code;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Remaining stages resolve metastability
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_reg[gi] <= '0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync_code = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic [AER_OH_WIDTH-1:0] cand_reg, cand_next;
  logic [RST_CNT_W-1:0]    rst_cnt_reg, rst_cnt_next;
  logic                    ack_reg, aer_rst_n_reg;
  logic                    push, err_inc, cand_onehot, full_int;
  logic [AER_ADDR_WIDTH-1:0] cand_addr;

  function automatic logic [AER_ADDR_WIDTH-1:0] encode(input logic [AER_OH_WIDTH-1:0] code);
    encode = '0;
    for (int i = 0; i < AER_OH_WIDTH; i++) begin
      if (code[i]) encode = encode | AER_ADDR_WIDTH'(i);
    end
  endfunction

  // cand is never zero in CHECK, so clearing the lowest set bit detects one-hot
  assign cand_onehot = ((cand_reg & (cand_reg - 1'b1)) == '0);
  assign cand_addr   = encode(cand_reg);

  // State, candidate code, array-reset counter and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= INIT;
      cand_reg      <= '0;
      rst_cnt_reg   <= '0;
      ack_reg       <= 1'b0;
      aer_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      rst_cnt_reg   <= rst_cnt_next;
      ack_reg       <= (state_next == ACK);
      aer_rst_n_reg <= (state_next != INIT);
    end
  end

  // Next-state decode: debounce, one-hot validation, backpressure stall
  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    rst_cnt_next = rst_cnt_reg;
    push         = 1'b0;
    err_inc      = 1'b0;
    case (state_reg)
      INIT: begin
        if (rst_cnt_reg == RST_CNT_LAST) state_next = IDLE;
        else                             rst_cnt_next = rst_cnt_reg + 1'b1;
      end
      IDLE: begin
        if (sync_code != '0) begin
          cand_next  = sync_code;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (sync_code != cand_reg) begin
          state_next = IDLE;
        end else if (cand_onehot) begin
          // A full FIFO leaves ack low, which stalls the array until a pop
          if (!full_int) begin
            push       = 1'b1;
            state_next = ACK;
          end
        end else begin
          err_inc    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (sync_code == '0) state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  assign aer.ack       = ack_reg;
  assign aer.aer_rst_n = aer_rst_n_reg;

  // ---------------------------------------------------------------------------
  // Collision counter
  // ---------------------------------------------------------------------------
  logic [7:0] err_cnt_reg;

  // Saturating count; a clear coinciding with a collision keeps that collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= err_inc ? 8'd1 : 8'd0;
    end else if (err_inc && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [AER_ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic                      pop;

  assign full_int = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop      = (count_reg != '0) && evt_ready;

  // Storage and pointers; pointers wrap naturally since depth is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_addr[i] <= '0;
    end else begin
      if (push) begin
        mem_addr[wr_ptr_reg] <= cand_addr;
        wr_ptr_reg           <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign evt_addr  = mem_addr[rd_ptr_reg];
  assign evt_valid = (count_reg != '0);
  assign fifo_full = full_int;

`ifdef AER_RX_TIMESTAMP_EN
  logic [15:0] ts_cnt_reg;
  logic [15:0] mem_ts [FIFO_DEPTH];

  // Free-running timestamp, wraps 65535 -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt_reg <= '0;
    else     ts_cnt_reg <= ts_cnt_reg + 16'd1;
  end

  // Timestamp sampled in the push cycle, stored next to the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_ts[i] <= '0;
    end else if (push) begin
      mem_ts[wr_ptr_reg] <= ts_cnt_reg;
    end
  end

  assign evt_ts = mem_ts[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_aer_rx_ctrl.sv
// Directed testbench for aer_rx_ctrl: reset/array-reset sequence, single
// event timing, collisions and counter saturation, backpressure ordering,
// glitch rejection, reset during a handshake, optional timestamps.
module tb_aer_rx_ctrl;
  import aer_pkg::*;

  localparam int W = AER_OH_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aer_intf aer_bus ();

  logic [AER_ADDR_WIDTH-1:0] evt_addr;
  logic                      evt_valid;
  logic                      evt_ready;
  logic [7:0]                err_cnt;
  logic                      err_clr;
  logic                      fifo_full;
`ifdef AER_RX_TIMESTAMP_EN
  logic [15:0]               evt_ts;
`endif

  aer_rx_ctrl #(
    .SYNC_STAGES      (2),
    .FIFO_DEPTH       (4),
    .ARRAY_RST_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .aer       (aer_bus),
    .evt_addr  (evt_addr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr),
    .fifo_full (fifo_full)
`ifdef AER_RX_TIMESTAMP_EN
    ,
    .evt_ts    (evt_ts)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] bit_code(input int idx);
    logic [W-1:0] one;
    one = W'(1);
    return one << idx;
  endfunction

  // Full request/ack/release cycle; reports ack latency and whether both
  // handshake phases completed within their bounds
  task automatic handshake(input logic [W-1:0] c, output int lat, output bit ok);
    int n;
    aer_bus.one_hot_code = c;
    lat = 0;
    ok  = 1'b0;
    n   = 0;
    while (aer_bus.ack !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (aer_bus.ack === 1'b1) begin
      aer_bus.one_hot_code = '0;
      while (aer_bus.ack !== 1'b0 && n < 40) begin
        tick();
        n++;
      end
      ok = (aer_bus.ack === 1'b0);
    end else begin
      aer_bus.one_hot_code = '0;
    end
    $display("handshake code=%h ack_latency=%0d release=%0d ok=%0d", c, lat, n, ok);
  endtask

  task automatic test_reset();
    bit seen_ack;
    rst = 1'b1;
    aer_bus.one_hot_code = '0;
    evt_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (3) tick();
    n_checks++; if (aer_bus.ack !== 1'b0) $display("FAIL reset_ack got %0b want 0", aer_bus.ack); else n_pass++;
    n_checks++; if (aer_bus.aer_rst_n !== 1'b0) $display("FAIL reset_aer_rst_n got %0b want 0", aer_bus.aer_rst_n); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid got %0b want 0", evt_valid); else n_pass++;
    n_checks++; if (evt_addr !== '0) $display("FAIL reset_evt_addr got %0d want 0", evt_addr); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_checks++; if (fifo_full !== 1'b0) $display("FAIL reset_fifo_full got %0b want 0", fifo_full); else n_pass++;
    // Release reset and raise a short request that lies entirely inside INIT
    rst = 1'b0;
    aer_bus.one_hot_code = bit_code(3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) aer_bus.one_hot_code = '0;
      n_checks++;
      if (aer_bus.aer_rst_n !== (i == 4))
        $display("FAIL init_aer_rst_n edge=%0d got %0b want %0b", i, aer_bus.aer_rst_n, (i == 4));
      else n_pass++;
    end
    seen_ack = 1'b0;
    repeat (8) begin
      tick();
      if (aer_bus.ack === 1'b1) seen_ack = 1'b1;
    end
    n_checks++; if (seen_ack !== 1'b0) $display("FAIL init_request_ack got %0b want 0", seen_ack); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL init_request_valid got %0b want 0", evt_valid); else n_pass++;
    $display("reset sequence done");
  endtask

  task automatic test_single_event();
    evt_ready = 1'b1;
    aer_bus.one_hot_code = bit_code(5);
    repeat (3) tick();
    n_checks++; if (aer_bus.ack !== 1'b0) $display("FAIL single_ack_early got %0b want 0", aer_bus.ack); else n_pass++;
    tick();
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL single_ack_rise got %0b want 1", aer_bus.ack); else n_pass++;
    n_checks++; if (evt_valid !== 1'b1) $display("FAIL single_evt_valid got %0b want 1", evt_valid); else n_pass++;
    n_checks++; if (evt_addr !== 4'd5) $display("FAIL single_evt_addr got %0d want 5", evt_addr); else n_pass++;
    tick();
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL single_valid_one_cycle got %0b want 0", evt_valid); else n_pass++;
    aer_bus.one_hot_code = '0;
    repeat (2) tick();
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL single_ack_hold got %0b want 1", aer_bus.ack); else n_pass++;
    tick();
    n_checks++; if (aer_bus.ack !== 1'b0) $display("FAIL single_ack_fall got %0b want 0", aer_bus.ack); else n_pass++;
    $display("single event addr=5 done");
  endtask

  task automatic test_collision();
    int lat;
    bit ok, all_ok;
    int n;
    evt_ready = 1'b1;
    aer_bus.one_hot_code = W'(16'b0110);
    repeat (4) tick();
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL coll_ack got %0b want 1", aer_bus.ack); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL coll_no_event got %0b want 0", evt_valid); else n_pass++;
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL coll_err_cnt got %0d want 1", err_cnt); else n_pass++;
    aer_bus.one_hot_code = '0;
    n = 0;
    while (aer_bus.ack !== 1'b0 && n < 40) begin tick(); n++; end
    all_ok = (aer_bus.ack === 1'b0);
    for (int i = 2; i <= 256; i++) begin
      handshake(W'(16'b0110), lat, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_checks++; if (all_ok !== 1'b1) $display("FAIL coll_handshakes got %0b want 1", all_ok); else n_pass++;
    n_checks++; if (err_cnt !== 8'd255) $display("FAIL coll_saturate got %0d want 255", err_cnt); else n_pass++;
    // Clear landing on the same edge as a collision leaves exactly one count
    aer_bus.one_hot_code = W'(16'b0110);
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err_cnt !== 8'd1) $display("FAIL coll_clr_same_cycle got %0d want 1", err_cnt); else n_pass++;
    aer_bus.one_hot_code = '0;
    n = 0;
    while (aer_bus.ack !== 1'b0 && n < 40) begin tick(); n++; end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err_cnt !== 8'd0) $display("FAIL coll_clr got %0d want 0", err_cnt); else n_pass++;
    $display("collision sequence done");
  endtask

  task automatic test_backpressure();
    int lat, n;
    bit ok, all_ok, stalled;
    int exp_q[4];
    exp_q = '{2, 3, 4, 7};
    evt_ready = 1'b0;
    all_ok = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      handshake(bit_code(a), lat, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_checks++; if (all_ok !== 1'b1) $display("FAIL bp_fill_handshakes got %0b want 1", all_ok); else n_pass++;
    n_checks++; if (fifo_full !== 1'b1) $display("FAIL bp_fifo_full got %0b want 1", fifo_full); else n_pass++;
    n_checks++; if (evt_addr !== 4'd1) $display("FAIL bp_head got %0d want 1", evt_addr); else n_pass++;
    aer_bus.one_hot_code = bit_code(7);
    stalled = 1'b1;
    repeat (10) begin
      tick();
      if (aer_bus.ack === 1'b1) stalled = 1'b0;
    end
    n_checks++; if (stalled !== 1'b1) $display("FAIL bp_stall_no_ack got %0b want 1", stalled); else n_pass++;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n = 0;
    while (aer_bus.ack !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL bp_ack_after_pop got %0b want 1", aer_bus.ack); else n_pass++;
    aer_bus.one_hot_code = '0;
    n = 0;
    while (aer_bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_addr !== AER_ADDR_WIDTH'(exp_q[k]))
        $display("FAIL bp_drain_%0d got valid=%0b addr=%0d want valid=1 addr=%0d", k, evt_valid, evt_addr, exp_q[k]);
      else n_pass++;
      $display("drain pop addr=%0d", evt_addr);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL bp_drained got %0b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_glitch();
    int lat;
    bit seen;
    int n;
    evt_ready = 1'b0;
    aer_bus.one_hot_code = W'(16'b0001);
    tick();
    aer_bus.one_hot_code = W'(16'b0010);
    lat = 1;
    while (aer_bus.ack !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_checks++; if (lat !== 6) $display("FAIL glitch_latency got %0d want 6", lat); else n_pass++;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_addr !== 4'd1)
      $display("FAIL glitch_event got valid=%0b addr=%0d want valid=1 addr=1", evt_valid, evt_addr);
    else n_pass++;
    aer_bus.one_hot_code = '0;
    n = 0;
    while (aer_bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL glitch_single_event got %0b want 0", evt_valid); else n_pass++;
    $display("glitch settle event addr=1 latency=%0d", lat);
    // One-cycle pulse never survives the second sample
    aer_bus.one_hot_code = W'(16'b1000);
    tick();
    aer_bus.one_hot_code = '0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (aer_bus.ack === 1'b1 || evt_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL glitch_pulse_rejected got %0b want 0", seen); else n_pass++;
    $display("glitch pulse rejected");
  endtask

  task automatic test_mid_reset();
    int lat, n;
    bit ok;
    evt_ready = 1'b0;
    handshake(bit_code(2), lat, ok);
    aer_bus.one_hot_code = bit_code(9);
    n = 0;
    while (aer_bus.ack !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL midrst_ack_before got %0b want 1", aer_bus.ack); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (aer_bus.ack !== 1'b0) $display("FAIL midrst_ack_async got %0b want 0", aer_bus.ack); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_valid_async got %0b want 0", evt_valid); else n_pass++;
    n_checks++; if (aer_bus.aer_rst_n !== 1'b0) $display("FAIL midrst_array_reset got %0b want 0", aer_bus.aer_rst_n); else n_pass++;
    aer_bus.one_hot_code = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    n_checks++; if (aer_bus.aer_rst_n !== 1'b1) $display("FAIL midrst_array_release got %0b want 1", aer_bus.aer_rst_n); else n_pass++;
    n_checks++; if (evt_valid !== 1'b0 || fifo_full !== 1'b0)
      $display("FAIL midrst_fifo_empty got valid=%0b full=%0b want 0 0", evt_valid, fifo_full);
    else n_pass++;
    $display("mid-handshake reset done");
  endtask

`ifdef AER_RX_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] ts0, ts1, diff;
    int n;
    evt_ready = 1'b0;
    aer_bus.one_hot_code = bit_code(1);
    repeat (4) tick();
    aer_bus.one_hot_code = '0;
    repeat (6) tick();
    aer_bus.one_hot_code = bit_code(2);
    repeat (4) tick();
    n_checks++; if (aer_bus.ack !== 1'b1) $display("FAIL ts_second_ack got %0b want 1", aer_bus.ack); else n_pass++;
    ts0 = evt_ts;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    ts1 = evt_ts;
    diff = ts1 - ts0;
    n_checks++; if (diff !== 16'd10) $display("FAIL ts_delta got %0d want 10", diff); else n_pass++;
    $display("timestamp events ts0=%0d ts1=%0d", ts0, ts1);
    aer_bus.one_hot_code = '0;
    n = 0;
    while (aer_bus.ack !== 1'b0 && n < 20) begin tick(); n++; end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_event();
    test_collision();
    test_backpressure();
    test_glitch();
`ifdef AER_RX_TIMESTAMP_EN
    test_timestamp();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
